// File: rtl/dmem_banked_stage_if.sv
// Request/response bundle for the banked data-memory stage.
// The parent pipeline drives requests and the stall; the stage returns results.
interface dmem_banked_stage_if #(
  parameter int DATA_W = 64,
  parameter int TAG_W  = 106
);
  logic              interlock;
  logic              req_valid;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [31:0]       req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              resp_valid;
  logic [TAG_W-1:0]  resp_tag;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output interlock, req_valid, req_we, req_size, req_signed,
           req_addr, req_wdata, req_tag,
    input  resp_valid, resp_tag, resp_rdata, resp_err
  );

  modport slave (
    input  interlock, req_valid, req_we, req_size, req_signed,
           req_addr, req_wdata, req_tag,
    output resp_valid, resp_tag, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_banked_stage.sv
// Banked data-memory stage: one load/store per cycle across BANKS read-first
// RAM banks, 2-cycle fixed latency, full freeze on interlock, swap-style
// store results (a store returns the word's prior contents).

// One synchronous read-first RAM bank with byte enables. Contents are never
// reset; the output register holds whenever the bank is not enabled.
module dmem_bank #(
  parameter  int DATA_W = 64,
  parameter  int DEPTH  = 4096,
  localparam int NB     = DATA_W / 8,
  localparam int IDX_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              en,
  input  logic [NB-1:0]     be,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Read old word and apply byte-enabled write on the same edge
  always_ff @(posedge clk) begin
    if (en) begin
      rdata <= mem[idx];
      for (int b = 0; b < NB; b++)
        if (be[b]) mem[idx][b*8 +: 8] <= wdata[b*8 +: 8];
    end
  end
endmodule

module dmem_banked_stage #(
  parameter int DATA_W     = 64,
  parameter int BANKS      = 8,
  parameter int BANK_DEPTH = 4096,
  parameter int TAG_W      = 106
) (
  input  logic               clk,
  input  logic               rstn,
  dmem_banked_stage_if.slave bus
);
  localparam int NB     = DATA_W / 8;
  localparam int OFF_W  = $clog2(NB);
  localparam int IDX_W  = $clog2(BANK_DEPTH);
  localparam int SEL_W  = $clog2(BANKS);
  localparam int USED_W = OFF_W + IDX_W + SEL_W;
  localparam int STAGES = 2;

  // ---- access-edge decode ----
  logic [OFF_W-1:0]  off;
  logic [IDX_W-1:0]  idx;
  logic [SEL_W-1:0]  sel;
  logic [3:0]        req_nb;
  logic              oor, misal, fault, acc;
  logic [NB-1:0]     lane_be;
  logic [DATA_W-1:0] lane_wd;

  assign off    = bus.req_addr[OFF_W-1:0];
  assign idx    = bus.req_addr[OFF_W +: IDX_W];
  assign sel    = bus.req_addr[OFF_W+IDX_W +: SEL_W];
  assign req_nb = 4'd1 << bus.req_size;
  assign oor    = (bus.req_addr >> USED_W) != 32'd0;
  assign misal  = (32'(req_nb) > NB) || ((32'(off) & (32'(req_nb) - 1)) != 0);
  assign fault  = oor | misal;
  // A RAM access happens only for a good, unstalled request out of reset
  assign acc    = rstn & ~bus.interlock & bus.req_valid & ~fault;

  // Byte-lane mask at the offset, store datum replicated across all lanes
  always_comb begin
    lane_be = '0;
    lane_wd = '0;
    for (int b = 0; b < NB; b++) begin
      lane_be[b]        = (b >= 32'(off)) && (b < 32'(off) + 32'(req_nb));
      lane_wd[b*8 +: 8] = bus.req_wdata[(b & (32'(req_nb) - 1))*8 +: 8];
    end
  end

  // ---- bank array ----
  logic [BANKS-1:0][DATA_W-1:0] bank_rd;

  for (genvar k = 0; k < BANKS; k++) begin : g_bank
    logic          bank_en;
    logic [NB-1:0] bank_be;
    assign bank_en = acc && (sel == SEL_W'(k));
    assign bank_be = (bank_en && bus.req_we) ? lane_be : '0;
    dmem_bank #(.DATA_W(DATA_W), .DEPTH(BANK_DEPTH)) u_bank (
      .clk   (clk),
      .en    (bank_en),
      .be    (bank_be),
      .idx   (idx),
      .wdata (lane_wd),
      .rdata (bank_rd[k])
    );
  end

  // ---- stage 1: fields travelling with the RAM read ----
  logic [STAGES:1]   vld_pipe;
  logic [TAG_W-1:0]  s1_tag;
  logic [SEL_W-1:0]  s1_sel;
  logic [OFF_W-1:0]  s1_off;
  logic [1:0]        s1_size;
  logic              s1_sgn, s1_err;

  // Capture access fields; everything freezes on interlock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe[1] <= 1'b0;
      s1_tag      <= '0;
      s1_sel      <= '0;
      s1_off      <= '0;
      s1_size     <= '0;
      s1_sgn      <= 1'b0;
      s1_err      <= 1'b0;
    end else if (!bus.interlock) begin
      vld_pipe[1] <= bus.req_valid;
      s1_tag      <= bus.req_tag;
      s1_sel      <= sel;
      s1_off      <= off;
      s1_size     <= bus.req_size;
      s1_sgn      <= bus.req_signed;
      s1_err      <= bus.req_valid & fault;
    end
  end

  // ---- stage 2: bank mux, extract, extend ----
  logic [DATA_W-1:0] s1_shift, s1_res;
  logic [3:0]        s1_nb;
  logic              s1_msb;

  // Shift the addressed bytes down, then sign/zero extend; faults return 0
  always_comb begin
    s1_shift = bank_rd[s1_sel] >> {s1_off, 3'b000};
    s1_nb    = 4'd1 << s1_size;
    s1_msb   = s1_shift[((32'(s1_nb) > NB) ? NB : 32'(s1_nb))*8 - 1];
    s1_res   = '0;
    for (int b = 0; b < NB; b++) begin
      if (b < 32'(s1_nb)) s1_res[b*8 +: 8] = s1_shift[b*8 +: 8];
      else                s1_res[b*8 +: 8] = {8{s1_sgn & s1_msb}};
    end
    if (s1_err) s1_res = '0;
  end

  logic [TAG_W-1:0]  r_tag;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  // Output register; holds on interlock
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_pipe[2] <= 1'b0;
      r_tag       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
    end else if (!bus.interlock) begin
      vld_pipe[2] <= vld_pipe[1];
      r_tag       <= s1_tag;
      r_rdata     <= s1_res;
      r_err       <= s1_err;
    end
  end

  assign bus.resp_valid = vld_pipe[STAGES];
  assign bus.resp_tag   = r_tag;
  assign bus.resp_rdata = r_rdata;
  assign bus.resp_err   = r_err;
endmodule

// File: tb/tb_dmem_banked_stage.sv
// Bench for dmem_banked_stage: directed table from the access rules, random
// traffic against a byte-addressed memory model, stall and async-reset cases.
module tb_dmem_banked_stage;
  localparam int DATA_W = 64;
  localparam int TAG_W  = 106;

  logic clk;
  logic rstn;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_banked_stage_if #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dif ();

  dmem_banked_stage #(.DATA_W(DATA_W), .BANKS(8), .BANK_DEPTH(4096), .TAG_W(TAG_W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (dif)
  );

  typedef struct {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [63:0]      rdata;
    logic             err;
  } resp_t;

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [63:0] wd;
    logic [63:0] exp_rd;
    logic        exp_err;
  } vec_t;

  logic [7:0]  mm [0:262143];   // byte-addressed view of the used range
  resp_t       stage_q[$];      // the one access between sampling and output
  resp_t       exp_out, zero_r;
  logic        chk_rd;
  int          vecs = 0, errs = 0;
  logic [31:0] pool [16];

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Result of one access from the memory rules; updates the model on stores
  function automatic resp_t model_access(input logic v, input logic we, input logic [1:0] sz,
                                         input logic sg, input logic [31:0] a,
                                         input logic [63:0] wd, input logic [TAG_W-1:0] tg);
    resp_t r;
    int n;
    r.valid = v; r.tag = tg; r.rdata = '0; r.err = 1'b0;
    if (!v) return r;
    n = 1 << sz;
    if (a[31:18] != 14'd0 || (a & 32'(n - 1)) != 32'd0) begin
      r.err = 1'b1;
      return r;
    end
    for (int i = 0; i < n; i++) r.rdata[8*i +: 8] = mm[int'(a) + i];
    if (sg && n < 8 && r.rdata[8*n-1])
      for (int i = n; i < 8; i++) r.rdata[8*i +: 8] = 8'hFF;
    if (we) for (int i = 0; i < n; i++) mm[int'(a) + i] = wd[8*i +: 8];
    return r;
  endfunction

  task automatic check_out();
    if (!rstn) begin
      check("rst_valid", 128'(dif.resp_valid), 128'(0));
      check("rst_tag",   128'(dif.resp_tag),   128'(0));
      check("rst_rdata", 128'(dif.resp_rdata), 128'(0));
      check("rst_err",   128'(dif.resp_err),   128'(0));
    end else begin
      check("valid", 128'(dif.resp_valid), 128'(exp_out.valid));
      check("tag",   128'(dif.resp_tag),   128'(exp_out.tag));
      if (exp_out.valid) begin
        check("err", 128'(dif.resp_err), 128'(exp_out.err));
        if (chk_rd) check("rdata", 128'(dif.resp_rdata), 128'(exp_out.rdata));
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model at the edge, check after it
  task automatic cycle(input logic v, input logic we, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [63:0] wd,
                       input logic [TAG_W-1:0] tg, input logic ilk);
    dif.interlock  = ilk;
    dif.req_valid  = v;
    dif.req_we     = we;
    dif.req_size   = sz;
    dif.req_signed = sg;
    dif.req_addr   = a;
    dif.req_wdata  = wd;
    dif.req_tag    = tg;
    @(posedge clk);
    if (!rstn) begin
      stage_q.delete();
      stage_q.push_back(zero_r);
      exp_out = zero_r;
    end else if (!ilk) begin
      stage_q.push_back(model_access(v, we, sz, sg, a, wd, tg));
      exp_out = stage_q.pop_front();
    end
    #1 check_out();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 2'd0, 1'b0, 32'd0, 64'd0, '0, 1'b0);
  endtask

  function automatic logic [TAG_W-1:0] rnd_tag();
    return TAG_W'({$urandom(), $urandom(), $urandom(), $urandom()});
  endfunction

  vec_t tbl [16];
  logic [TAG_W-1:0] ta, tb, tc;
  logic [TAG_W-1:0] seq_tag [6];
  int nresp;

  initial begin
    zero_r.valid = 1'b0; zero_r.tag = '0; zero_r.rdata = '0; zero_r.err = 1'b0;
    stage_q.push_back(zero_r);
    exp_out = zero_r;
    chk_rd  = 1'b0;
    rstn    = 1'b0;
    for (int i = 0; i < 16; i++) pool[i] = 32'((i % 8) << 15) | 32'((i / 8) << 3);

    //         we  sz    sg    addr           wdata                    expected rdata           err
    tbl[0]  = '{1, 2'd3, 0, 32'h0000_8000, 64'h1122334455667788, 64'h5A5A5A5A00008000, 0};
    tbl[1]  = '{0, 2'd3, 0, 32'h0000_8000, 64'h0,                64'h1122334455667788, 0};
    tbl[2]  = '{0, 2'd3, 0, 32'h0000_0000, 64'h0,                64'h5A5A5A5A00000000, 0};
    tbl[3]  = '{1, 2'd0, 0, 32'h0000_8003, 64'hAB,               64'h0000000000000055, 0};
    tbl[4]  = '{0, 2'd3, 0, 32'h0000_8000, 64'h0,                64'h11223344AB667788, 0};
    tbl[5]  = '{0, 2'd0, 1, 32'h0000_8003, 64'h0,                64'hFFFFFFFFFFFFFFAB, 0};
    tbl[6]  = '{0, 2'd0, 0, 32'h0000_8003, 64'h0,                64'h00000000000000AB, 0};
    tbl[7]  = '{1, 2'd2, 0, 32'h0000_8000, 64'hDEADBEEF,         64'h00000000AB667788, 0};
    tbl[8]  = '{0, 2'd3, 0, 32'h0000_8000, 64'h0,                64'h11223344DEADBEEF, 0};
    tbl[9]  = '{0, 2'd1, 0, 32'h0000_8001, 64'h0,                64'h0,                1};
    tbl[10] = '{1, 2'd3, 0, 32'h0004_0000, 64'hFFFFFFFFFFFFFFFF, 64'h0,                1};
    tbl[11] = '{0, 2'd3, 0, 32'h0000_0000, 64'h0,                64'h5A5A5A5A00000000, 0};
    tbl[12] = '{0, 2'd2, 1, 32'h0000_8000, 64'h0,                64'hFFFFFFFFDEADBEEF, 0};
    tbl[13] = '{0, 2'd1, 1, 32'h0000_8006, 64'h0,                64'h0000000000001122, 0};
    tbl[14] = '{0, 2'd0, 0, 32'h4000_0003, 64'h0,                64'h0,                1};
    tbl[15] = '{0, 2'd3, 0, 32'h0000_8008, 64'h0,                64'h5A5A5A5A00008008, 0};

    // Reset state
    idle(); idle();
    #2 rstn = 1'b1;

    // Give every pool word a known value; prior RAM contents are undefined
    for (int i = 0; i < 16; i++)
      cycle(1'b1, 1'b1, 2'd3, 1'b0, pool[i], {32'h5A5A5A5A, pool[i]}, rnd_tag(), 1'b0);
    idle(); idle();
    chk_rd = 1'b1;

    // Directed table: each result checked two edges after its issue
    for (int i = 0; i < 16; i++) begin
      cycle(1'b1, tbl[i].we, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, TAG_W'(i + 100), 1'b0);
      idle();
      check($sformatf("tbl%0d_valid", i), 128'(dif.resp_valid), 128'(1));
      check($sformatf("tbl%0d_tag", i),   128'(dif.resp_tag),   128'(i + 100));
      check($sformatf("tbl%0d_rdata", i), 128'(dif.resp_rdata), 128'(tbl[i].exp_rd));
      check($sformatf("tbl%0d_err", i),   128'(dif.resp_err),   128'(tbl[i].exp_err));
    end

    // Random traffic over the pool, with faults and stalls mixed in
    for (int n = 0; n < 800; n++) begin
      logic [31:0] a;
      a = pool[$urandom_range(0, 15)] + 32'($urandom_range(0, 7));
      if ($urandom_range(0, 15) == 0) a = a | (32'd1 << $urandom_range(18, 31));
      cycle($urandom_range(0, 3) != 0, 1'($urandom()), 2'($urandom_range(0, 3)), 1'($urandom()),
            a, {$urandom(), $urandom()}, rnd_tag(), $urandom_range(0, 5) == 0);
    end
    idle(); idle();

    // Back-to-back A,B then C held under a 3-cycle interlock
    ta = rnd_tag(); tb = rnd_tag(); tc = rnd_tag();
    seq_tag[0] = ta; seq_tag[1] = ta; seq_tag[2] = ta; seq_tag[3] = ta;
    seq_tag[4] = tb; seq_tag[5] = tc;
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_0000, 64'd0, ta, 1'b0);
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_8008, 64'd0, tb, 1'b0);
    check("stall_0_valid", 128'(dif.resp_valid), 128'(1));
    check("stall_0_tag",   128'(dif.resp_tag),   128'(seq_tag[0]));
    for (int s = 1; s <= 3; s++) begin
      cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h0001_0000, 64'd0, tc, 1'b1);
      check($sformatf("stall_%0d_valid", s), 128'(dif.resp_valid), 128'(1));
      check($sformatf("stall_%0d_tag", s),   128'(dif.resp_tag),   128'(seq_tag[s]));
    end
    cycle(1'b1, 1'b0, 2'd2, 1'b0, 32'h0001_0000, 64'd0, tc, 1'b0);
    check("stall_4_valid", 128'(dif.resp_valid), 128'(1));
    check("stall_4_tag",   128'(dif.resp_tag),   128'(seq_tag[4]));
    idle();
    check("stall_5_valid", 128'(dif.resp_valid), 128'(1));
    check("stall_5_tag",   128'(dif.resp_tag),   128'(seq_tag[5]));
    idle();
    check("stall_6_valid", 128'(dif.resp_valid), 128'(0));

    // Async reset mid-cycle with two loads in flight
    cycle(1'b1, 1'b1, 2'd3, 1'b0, 32'h0001_0008, 64'hCAFEF00D12345678, rnd_tag(), 1'b0);
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 32'h0001_0008, 64'd0, rnd_tag(), 1'b0);
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 32'h0000_8000, 64'd0, rnd_tag(), 1'b0);
    check("pre_rst_valid", 128'(dif.resp_valid), 128'(1));
    #2 rstn = 1'b0;
    #1 check_out();
    // A store presented during reset must not land
    cycle(1'b1, 1'b1, 2'd3, 1'b0, 32'h0001_8000, 64'h0BAD0BAD0BAD0BAD, rnd_tag(), 1'b0);
    cycle(1'b1, 1'b1, 2'd3, 1'b0, 32'h0001_8000, 64'h0BAD0BAD0BAD0BAD, rnd_tag(), 1'b0);
    #2 rstn = 1'b1;
    nresp = 0;
    for (int i = 0; i < 3; i++) begin
      idle();
      if (dif.resp_valid) nresp++;
    end
    check("no_resp_after_rst", 128'(nresp), 128'(0));
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 32'h0001_0008, 64'd0, rnd_tag(), 1'b0);
    idle();
    check("store_survives_rst", 128'(dif.resp_rdata), 128'(64'hCAFEF00D12345678));
    cycle(1'b1, 1'b0, 2'd3, 1'b0, 32'h0001_8000, 64'd0, rnd_tag(), 1'b0);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
